// File: rtl/counter_pkg.sv
// counter_pkg: direction constants and terminal-count helper shared by the counter slice
package counter_pkg;
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DOWN = 1'b0;
    function automatic logic [31:0] max_count(input int width, input int modulus);
        return 32'(modulus - 1) & ((width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1));
    endfunction
endpackage

// File: rtl/counter_tc.sv
// counter_tc: terminal-count detect, suppressed while a higher-priority command is active
module counter_tc
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX = '1
) (
    input  logic [WIDTH-1:0] nums,
    input  logic             up,
    input  logic             en,
    input  logic             block,
    output logic             cout
);
    assign cout = en && !block && ((up == CNT_UP) ? (nums == MAX) : (nums == '0));
endmodule

// File: rtl/counter_mod.sv
// counter_mod: modulo up/down counter with load, clear, saturate option and sticky overflow
module counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODULUS = 2 ** WIDTH,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] nums,
    output logic             cout,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH, MODULUS));
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] wrap;
    assign step = (up == CNT_UP) ? nums + WIDTH'(1) : nums - WIDTH'(1);
    assign wrap = (SATURATE != 0) ? nums : ((up == CNT_UP) ? '0 : MAX);
    counter_tc #(.WIDTH(WIDTH), .MAX(MAX)) u_tc (
        .nums  (nums),
        .up    (up),
        .en    (en),
        .block (rst | clr | load),
        .cout  (cout)
    );
    // cout already implies en with no higher-priority command, so it selects wrap vs step
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            nums <= '0;
            ovf  <= 1'b0;
        end else if (load) begin
            nums <= (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            nums <= cout ? wrap : step;
            ovf  <= ovf | cout;
        end
    end
endmodule

// File: tb/tb_counter_mod.sv
// tb_counter_mod: directed scoreboard bench for wrap, saturate, priority, reset and cascade
module tb_counter_mod;
    import counter_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic load = 1'b0;
    logic en = 1'b0;
    logic up = CNT_UP;
    logic casc_en = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] a_nums, b_nums, lo_nums, hi_nums;
    logic a_cout, b_cout, lo_cout, hi_cout;
    logic a_ovf, b_ovf, lo_ovf, hi_ovf;
    int compared = 0;
    int mismatched = 0;
    int sel = 0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .nums(a_nums), .cout(a_cout), .ovf(a_ovf));
    counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .nums(b_nums), .cout(b_cout), .ovf(b_ovf));
    counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
        .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(casc_en), .up(CNT_UP), .nums(lo_nums), .cout(lo_cout), .ovf(lo_ovf));
    counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
        .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(lo_cout), .up(CNT_UP), .nums(hi_nums), .cout(hi_cout), .ovf(hi_ovf));

    function automatic logic [8:0] st(input logic o, input int n);
        return {o, 4'd0, 4'(n)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs are already driven; expected post-edge state is queued, cout checked before the edge
    task automatic cyc(input string tag, input logic ec, input logic [8:0] exp);
        logic [8:0] e;
        logic oc;
        logic [8:0] os;
        q.push_back(exp);
        #2;
        oc = (sel == 1) ? b_cout : (sel == 2) ? lo_cout : a_cout;
        chk({tag, "_cout"}, {31'd0, oc}, {31'd0, ec});
        @(posedge clk);
        #1;
        e = q.pop_front();
        os = (sel == 1) ? {b_ovf, 4'd0, b_nums} : (sel == 2) ? {hi_ovf, hi_nums, lo_nums} : {a_ovf, 4'd0, a_nums};
        chk({tag, "_state"}, {23'd0, os}, {23'd0, e});
    endtask

    initial begin
        cyc("reset", 1'b0, st(1'b0, 0));
        rst = 1'b0;
        en = 1'b1;
        up = CNT_UP;
        for (int i = 0; i < 12; i++) cyc("up_wrap", i == 9, st(i >= 9, (i + 1) % 10));
        clr = 1'b1;
        load = 1'b1;
        load_val = 4'd5;
        cyc("clr_load", 1'b0, st(1'b0, 0));
        clr = 1'b0;
        load_val = 4'd2;
        cyc("load2", 1'b0, st(1'b0, 2));
        load = 1'b0;
        up = CNT_DOWN;
        cyc("down", 1'b0, st(1'b0, 1));
        cyc("down", 1'b0, st(1'b0, 0));
        cyc("down_wrap", 1'b1, st(1'b1, 9));
        cyc("down", 1'b0, st(1'b1, 8));
        load = 1'b1;
        load_val = 4'd5;
        cyc("load_en", 1'b0, st(1'b1, 5));
        load_val = 4'd14;
        cyc("load_clip", 1'b0, st(1'b1, 9));
        load = 1'b0;
        up = CNT_UP;
        en = 1'b0;
        cyc("hold_ovf", 1'b0, st(1'b1, 9));
        clr = 1'b1;
        cyc("clr", 1'b0, st(1'b0, 0));
        clr = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 6; i++) cyc("count6", 1'b0, st(1'b0, i + 1));
        rst = 1'b1;
        cyc("rst_mid", 1'b0, st(1'b0, 0));
        rst = 1'b0;
        cyc("resume", 1'b0, st(1'b0, 1));
        en = 1'b0;
        cyc("hold", 1'b0, st(1'b0, 1));
        load = 1'b1;
        load_val = 4'd9;
        cyc("load9", 1'b0, st(1'b0, 9));
        load = 1'b0;
        rst = 1'b1;
        en = 1'b1;
        cyc("rst_cout", 1'b0, st(1'b0, 0));
        rst = 1'b0;
        en = 1'b0;
        sel = 1;
        load = 1'b1;
        load_val = 4'd8;
        cyc("sat_load", 1'b0, st(1'b0, 8));
        load = 1'b0;
        en = 1'b1;
        cyc("sat_up", 1'b0, st(1'b0, 9));
        cyc("sat_hold", 1'b1, st(1'b1, 9));
        cyc("sat_hold", 1'b1, st(1'b1, 9));
        en = 1'b0;
        clr = 1'b1;
        cyc("sat_clr", 1'b0, st(1'b0, 0));
        clr = 1'b0;
        en = 1'b1;
        up = CNT_DOWN;
        cyc("sat_down", 1'b1, st(1'b1, 0));
        en = 1'b0;
        sel = 2;
        casc_en = 1'b1;
        for (int k = 0; k < 100; k++)
            cyc("cascade", (k % 10) == 9, {k == 99, 4'(((k + 1) / 10) % 10), 4'((k + 1) % 10)});
        casc_en = 1'b0;
        chk("hi_cout_idle", {31'd0, hi_cout}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
